mac_sched: RTL and testbench
============================

Name: mac_sched

Overview:
- Sequencing controller and two-requester arbiter for the shared 3x3 matrix MAC datapath (8-bit elements, 72-bit packed matrices).
- Accepts matrix commands from two requesters over valid/ready, round-robin arbitrated.
- Drives one internal mac instance for one or two passes per command, registering each pass result.
- Returns the result on a valid/ready response channel tagged with the requester id.

Parameters:
- DATA_WIDTH, 72, packed matrix width (MAT_SIZE*MAT_SIZE*VAR_WIDTH); passed to mac.
- MAT_SIZE, 3, matrix dimension; passed to mac.
- VAR_WIDTH, 8, element width; passed to mac.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req0_valid_i  in  1  requester 0 command valid
- req0_ready_o  out  1  requester 0 command accepted this cycle when valid&ready
- req0_op_i  in  3  requester 0 opcode
- req0_a_i / req0_b_i / req0_c_i  in  DATA_WIDTH each  requester 0 operands A, B, C
- req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i, req1_c_i  same as requester 0
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_id_o  out  1  requester id of response
- rsp_data_o  out  DATA_WIDTH  result matrix
- rsp_err_o  out  1  illegal opcode flag
- busy_o  out  1  high in any state other than IDLE

Behaviour:
- Packing: element [0][0] occupies the MSBs [71:64]; row-major down to [2][2] at [7:0].
- Arithmetic: per element modulo 2^VAR_WIDTH; products and sums truncated, no saturation.
- mac_op_t encoding: MADD=2'b00, MSUB=2'b01, MMUL=2'b10.
- Opcodes:
  - 000 ADD: A+B, 1 pass.
  - 001 SUB: A-B, 1 pass.
  - 010 MUL: A*B, 1 pass.
  - 011 MULADD: A*B+C, pass1 MMUL(A,B), pass2 MADD(P,C).
  - 100 MULSUB: A*B-C, pass2 MSUB(P,C).
  - 101 SQUARE: A*A, 1 pass; B ignored.
  - 110/111: illegal.
- C is ignored for every op except MULADD and MULSUB.
- States:
  - IDLE: arbitrate; on handshake capture op, A, B, C and id. Illegal op goes to RESP; otherwise to PASS1.
  - PASS1: mac driven from captured operands; result register loads the mac output at the end of the cycle. Goes to PASS2 for MULADD/MULSUB, else to RESP.
  - PASS2: mac driven with (result register, C); result register reloads. Goes to RESP.
  - RESP: rsp_valid_o=1; rsp_data_o, rsp_id_o and rsp_err_o held stable until rsp_ready_i=1, then to IDLE.
- Latency, handshake in cycle T:
  - 1-pass ops: rsp_valid_o first high in T+2.
  - 2-pass ops: rsp_valid_o first high in T+3.
  - Illegal op: rsp_valid_o first high in T+1, with rsp_err_o=1 and rsp_data_o=0.
- Acceptance:
  - reqK_ready_o = (state==IDLE) && grant==K; combinational.
  - Only IDLE accepts; no accept in the cycle the response handshakes.
  - Minimum issue interval is 3 cycles for 1-pass ops.
- Arbitration:
  - Round-robin on a last_grant register.
  - If both requesters are valid, grant goes to !last_grant; if one is valid, it is granted.
  - last_grant updates only on an accepted handshake.
  - last_grant resets to 1, so requester 0 wins the first contested cycle.
- Requester rule: op and operands stay stable while valid is high and unaccepted. A requester may drop valid before acceptance without effect.
- mac_op in IDLE/RESP is driven to MADD; the result register does not load there.
- Reset (rst_ni=0 at a clock edge):
  - state=IDLE; result register=0; captured regs=0; last_grant=1.
  - rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0, busy_o=0.
  - reqK_ready_o=0 while rst_ni=0.
  - An in-flight command is dropped with no response.
  - The first accept is possible in the first cycle with rst_ni=1.
- Simultaneous events in RESP: new request valids are ignored until IDLE; a request dropped meanwhile is never recorded.

Test Plan:
- Single-pass latency: req0 ADD, A all 0x01, B all 0x02 -> rsp_data_o all 0x03, rsp_id_o=0, rsp_err_o=0, rsp_valid_o high at T+2.
- MUL and SQUARE: req1 MUL, A=identity (diag 0x01), B=0x01..0x09 row-major -> rsp_data_o=B, rsp_id_o=1. Then SQUARE with A all 0x02 -> all 0x0C.
- Two-pass with wrap:
  - MULADD, A=B all 0x10, C all 0x01 -> all 0x01 at T+3 (3*0x100 wraps to 0).
  - MULSUB with same operands -> all 0xFF.
- Arbitration: both requesters hold ADD valid continuously, rsp_ready_i=1 -> accepts alternate id 0,1,0,1; each accept 3 cycles apart; busy_o low only in accept cycles.
- Backpressure: rsp_ready_i low 5 cycles after rsp_valid_o -> rsp_data_o/rsp_id_o stable, both reqK_ready_o low; accept resumes the cycle after the response handshake.
- Illegal opcode and reset:
  - op 3'b111 -> rsp_valid_o at T+1, rsp_err_o=1, rsp_data_o=0.
  - rst_ni low for one cycle during PASS2 of a MULADD -> no response ever appears; with both requesters valid after reset, requester 0 is granted first.

Source files
------------

// File: rtl/mac_sched.sv
// mac_sched: round-robin front end for two requesters that sequences one shared
// 3x3 matrix MAC through one or two passes per command and returns the result.

package mac_sched_pkg;
    typedef enum logic [1:0] {
        MADD = 2'b00,
        MSUB = 2'b01,
        MMUL = 2'b10
    } mac_op_t;
endpackage

module mac #(
    parameter int DATA_WIDTH = 72,
    parameter int MAT_SIZE   = 3,
    parameter int VAR_WIDTH  = 8
) (
    input  logic [1:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] y_o
);
    import mac_sched_pkg::*;

    localparam int NUM_EL = MAT_SIZE * MAT_SIZE;

    // Element [0][0] sits in the MSBs, row-major towards the LSBs.
    function automatic logic [VAR_WIDTH-1:0] elem(input logic [DATA_WIDTH-1:0] m,
                                                   input int r, input int c);
        return m[(NUM_EL - 1 - (r * MAT_SIZE + c)) * VAR_WIDTH +: VAR_WIDTH];
    endfunction

    logic [VAR_WIDTH-1:0] acc_s;

    // Element-wise add/sub or row-by-column product, everything modulo 2^VAR_WIDTH.
    always_comb begin
        y_o   = '0;
        acc_s = '0;
        for (int i = 0; i < MAT_SIZE; i++) begin
            for (int j = 0; j < MAT_SIZE; j++) begin
                acc_s = '0;
                case (op_i)
                    MADD: acc_s = elem(a_i, i, j) + elem(b_i, i, j);
                    MSUB: acc_s = elem(a_i, i, j) - elem(b_i, i, j);
                    MMUL: begin
                        for (int k = 0; k < MAT_SIZE; k++) begin
                            acc_s = acc_s + elem(a_i, i, k) * elem(b_i, k, j);
                        end
                    end
                    default: acc_s = '0;
                endcase
                y_o[(NUM_EL - 1 - (i * MAT_SIZE + j)) * VAR_WIDTH +: VAR_WIDTH] = acc_s;
            end
        end
    end
endmodule

module mac_sched #(
    parameter int DATA_WIDTH = 72,
    parameter int MAT_SIZE   = 3,
    parameter int VAR_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [2:0]            req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    input  logic [DATA_WIDTH-1:0] req0_c_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [2:0]            req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    input  logic [DATA_WIDTH-1:0] req1_c_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_err_o,
    output logic                  busy_o
);
    import mac_sched_pkg::*;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_PASS1 = 2'b01,
        S_PASS2 = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_MULADD = 3'b011;
    localparam logic [2:0] OP_MULSUB = 3'b100;
    localparam logic [2:0] OP_SQUARE = 3'b101;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  id_q, id_d;
    logic                  err_q, err_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [DATA_WIDTH-1:0] c_q, c_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  grant_s;
    logic                  idle_s;
    logic                  accept_s;
    logic [2:0]            sel_op_s;
    logic [DATA_WIDTH-1:0] sel_a_s;
    logic [DATA_WIDTH-1:0] sel_b_s;
    logic [DATA_WIDTH-1:0] sel_c_s;
    mac_op_t               mac_op_s;
    logic [DATA_WIDTH-1:0] mac_a_s;
    logic [DATA_WIDTH-1:0] mac_b_s;
    logic [DATA_WIDTH-1:0] mac_y_s;

    // Round-robin grant; ready is held low during reset even though state is IDLE.
    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            grant_s = ~last_grant_q;
        end else if (req0_valid_i) begin
            grant_s = 1'b0;
        end else if (req1_valid_i) begin
            grant_s = 1'b1;
        end else begin
            grant_s = ~last_grant_q;
        end
        idle_s       = (state_q == S_IDLE) && rst_ni;
        req0_ready_o = idle_s && !grant_s;
        req1_ready_o = idle_s && grant_s;
        accept_s     = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
        sel_op_s     = grant_s ? req1_op_i : req0_op_i;
        sel_a_s      = grant_s ? req1_a_i  : req0_a_i;
        sel_b_s      = grant_s ? req1_b_i  : req0_b_i;
        sel_c_s      = grant_s ? req1_c_i  : req0_c_i;
    end

    // MAC operand and operation selection for the current pass.
    always_comb begin
        mac_op_s = MADD;
        mac_a_s  = a_q;
        mac_b_s  = b_q;
        case (state_q)
            S_PASS1: begin
                case (op_q)
                    OP_ADD:    mac_op_s = MADD;
                    OP_SUB:    mac_op_s = MSUB;
                    OP_SQUARE: begin
                        mac_op_s = MMUL;
                        mac_b_s  = a_q;
                    end
                    default:   mac_op_s = MMUL;
                endcase
            end
            S_PASS2: begin
                mac_a_s  = result_q;
                mac_b_s  = c_q;
                mac_op_s = (op_q == OP_MULSUB) ? MSUB : MADD;
            end
            default: mac_op_s = MADD;
        endcase
    end

    mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAT_SIZE   (MAT_SIZE),
        .VAR_WIDTH  (VAR_WIDTH)
    ) u_mac (
        .op_i (mac_op_s),
        .a_i  (mac_a_s),
        .b_i  (mac_b_s),
        .y_o  (mac_y_s)
    );

    // Sequencer next-state: capture in IDLE, one or two passes, hold in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        err_d        = err_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        result_d     = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    last_grant_d = grant_s;
                    id_d         = grant_s;
                    op_d         = sel_op_s;
                    a_d          = sel_a_s;
                    b_d          = sel_b_s;
                    c_d          = sel_c_s;
                    err_d        = (sel_op_s > OP_SQUARE);
                    state_d      = (sel_op_s > OP_SQUARE) ? S_RESP : S_PASS1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PASS1: begin
                result_d = mac_y_s;
                if ((op_q == OP_MULADD) || (op_q == OP_MULSUB)) begin
                    state_d = S_PASS2;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_PASS2: begin
                result_d = mac_y_s;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            err_q        <= 1'b0;
            op_q         <= 3'b000;
            a_q          <= '0;
            b_q          <= '0;
            c_q          <= '0;
            result_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            err_q        <= err_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            result_q     <= result_d;
        end
    end

    // An illegal opcode never loads the result register, so its data is forced to zero.
    assign rsp_valid_o = (state_q == S_RESP);
    assign busy_o      = (state_q != S_IDLE);
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;
    assign rsp_data_o  = err_q ? {DATA_WIDTH{1'b0}} : result_q;

endmodule

// File: tb/tb_mac_sched.sv
// Randomized scoreboard bench for mac_sched: expectations come from a plain
// integer matrix model; a negedge monitor pops and checks every response.

module tb_mac_sched;
    localparam int DW = 72;

    logic          clk_i        = 1'b0;
    logic          rst_ni       = 1'b0;
    logic          req0_valid_i = 1'b0;
    logic          req0_ready_o;
    logic [2:0]    req0_op_i    = 3'd0;
    logic [DW-1:0] req0_a_i     = '0;
    logic [DW-1:0] req0_b_i     = '0;
    logic [DW-1:0] req0_c_i     = '0;
    logic          req1_valid_i = 1'b0;
    logic          req1_ready_o;
    logic [2:0]    req1_op_i    = 3'd0;
    logic [DW-1:0] req1_a_i     = '0;
    logic [DW-1:0] req1_b_i     = '0;
    logic [DW-1:0] req1_c_i     = '0;
    logic          rsp_valid_o;
    logic          rsp_ready_i  = 1'b1;
    logic          rsp_id_o;
    logic [DW-1:0] rsp_data_o;
    logic          rsp_err_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    mac_sched dut (
        .clk_i (clk_i), .rst_ni (rst_ni),
        .req0_valid_i (req0_valid_i), .req0_ready_o (req0_ready_o), .req0_op_i (req0_op_i),
        .req0_a_i (req0_a_i), .req0_b_i (req0_b_i), .req0_c_i (req0_c_i),
        .req1_valid_i (req1_valid_i), .req1_ready_o (req1_ready_o), .req1_op_i (req1_op_i),
        .req1_a_i (req1_a_i), .req1_b_i (req1_b_i), .req1_c_i (req1_c_i),
        .rsp_valid_o (rsp_valid_o), .rsp_ready_i (rsp_ready_i), .rsp_id_o (rsp_id_o),
        .rsp_data_o (rsp_data_o), .rsp_err_o (rsp_err_o), .busy_o (busy_o)
    );

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        logic          err;
        int            lat;
        int            t;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   tmo   = 0;
    int   phase = 0;
    bit   final_req = 1'b0;
    bit   mon_done  = 1'b0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic int el(input logic [DW-1:0] m, input int r, input int c);
        logic [DW-1:0] t;
        t = m >> (8 * (8 - (r * 3 + c)));
        return int'(t[7:0]);
    endfunction

    // kind 0 = add, 1 = sub, 2 = matrix product
    function automatic logic [DW-1:0] mat(input int kind, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
        logic [DW-1:0] res;
        int v;
        res = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (kind == 0) v = el(x, i, j) + el(y, i, j);
                else if (kind == 1) v = el(x, i, j) - el(y, i, j) + 256;
                else begin
                    v = 0;
                    for (int k = 0; k < 3; k++) v = v + el(x, i, k) * el(y, k, j);
                end
                res = (res << 8) | {64'd0, 8'(v % 256)};
            end
        end
        return res;
    endfunction

    task automatic ref_model(input logic [2:0] op, input logic [DW-1:0] a, b, c,
                             output logic [DW-1:0] d, output logic er, output int lat);
        er = 1'b0; lat = 2; d = '0;
        case (op)
            3'd0: d = mat(0, a, b);
            3'd1: d = mat(1, a, b);
            3'd2: d = mat(2, a, b);
            3'd3: begin d = mat(0, mat(2, a, b), c); lat = 3; end
            3'd4: begin d = mat(1, mat(2, a, b), c); lat = 3; end
            3'd5: d = mat(2, a, a);
            default: begin er = 1'b1; lat = 1; end
        endcase
    endtask

    function automatic logic [DW-1:0] rnd_mat();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic chk(input string nm, input logic [95:0] got, input logic [95:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, expv, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t e;
        logic [DW-1:0] d;
        logic er, acc0, acc1, last_g, rst_prev, prev_valid, chk_first;
        int lt, last_acc, last_hs, prev_phase, tmo_seen, rel_cyc;
        last_g = 1'b1; rst_prev = 1'b1; prev_valid = 1'b0; chk_first = 1'b0;
        last_acc = -1; last_hs = -100; prev_phase = 0; tmo_seen = 0; rel_cyc = 0;
        forever begin
            @(negedge clk_i);
            if (tmo != tmo_seen) begin
                chk("wait_timeout", 96'(tmo), 96'(tmo_seen));
                tmo_seen = tmo;
            end
            if (phase != prev_phase) last_acc = -1;
            prev_phase = phase;
            if (!rst_ni) begin
                chk("reset_ready", {94'd0, req0_ready_o, req1_ready_o}, 96'd0);
                if (!rst_prev)
                    chk("reset_outputs", {19'd0, rsp_valid_o, busy_o, rsp_id_o, rsp_err_o, rsp_data_o}, 96'd0);
                exp_q.delete();
                last_g = 1'b1;
                prev_valid = 1'b0;
            end else begin
                if (!rst_prev) begin rel_cyc = cyc; chk_first = 1'b1; end
                if (rsp_valid_o) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 96'd1, 96'd0);
                    end else begin
                        e = exp_q[0];
                        if (!prev_valid) chk("latency", 96'(cyc - e.t), 96'(e.lat));
                        chk("ready_low_in_resp", {94'd0, req0_ready_o, req1_ready_o}, 96'd0);
                        chk("rsp_fields", {22'd0, rsp_id_o, rsp_err_o, rsp_data_o},
                            {22'd0, e.id, e.err, e.data});
                        if (rsp_ready_i) begin
                            void'(exp_q.pop_front());
                            last_hs = cyc;
                        end
                    end
                end
                prev_valid = rsp_valid_o;
                acc0 = req0_valid_i && req0_ready_o;
                acc1 = req1_valid_i && req1_ready_o;
                if (acc0 && acc1) begin
                    chk("double_grant", 96'd1, 96'd0);
                end else if (acc0 || acc1) begin
                    if (req0_valid_i && req1_valid_i) chk("rr_grant", {95'd0, acc1}, {95'd0, ~last_g});
                    if (phase == 1 && last_acc >= 0) chk("issue_interval", 96'(cyc - last_acc), 96'd3);
                    if (phase == 2) chk("resume_after_hs", 96'(cyc), 96'(last_hs + 1));
                    if (phase == 3 && chk_first) chk("first_accept", 96'(cyc), 96'(rel_cyc));
                    chk_first = 1'b0;
                    if (acc1) ref_model(req1_op_i, req1_a_i, req1_b_i, req1_c_i, d, er, lt);
                    else      ref_model(req0_op_i, req0_a_i, req0_b_i, req0_c_i, d, er, lt);
                    e.id = acc1; e.data = d; e.err = er; e.lat = lt; e.t = cyc;
                    exp_q.push_back(e);
                    last_g = acc1;
                    last_acc = cyc;
                end
                if (phase == 1) chk("busy_vs_accept", {95'd0, busy_o}, {95'd0, ~(acc0 | acc1)});
                if (final_req && !mon_done) begin
                    chk("queue_drained", 96'(exp_q.size()), 96'd0);
                    mon_done = 1'b1;
                end
            end
            rst_prev = rst_ni;
        end
    end

    // ---------------- stimulus ----------------
    task automatic run_cmds(input bit v0, input logic [2:0] o0, input logic [DW-1:0] a0, b0, c0,
                            input bit v1, input logic [2:0] o1, input logic [DW-1:0] a1, b1, c1,
                            input bit rnd_ready);
        int g;
        bit f0, f1;
        req0_valid_i = v0; req0_op_i = o0; req0_a_i = a0; req0_b_i = b0; req0_c_i = c0;
        req1_valid_i = v1; req1_op_i = o1; req1_a_i = a1; req1_b_i = b1; req1_c_i = c1;
        g = 0;
        while ((req0_valid_i || req1_valid_i) && g < 80) begin
            @(negedge clk_i);
            f0 = req0_valid_i && req0_ready_o;
            f1 = req1_valid_i && req1_ready_o;
            @(posedge clk_i); #1;
            if (f0) req0_valid_i = 1'b0;
            if (f1) req1_valid_i = 1'b0;
            if (rnd_ready) rsp_ready_i = ($urandom_range(0, 3) != 0);
            g++;
        end
        if (req0_valid_i || req1_valid_i) begin
            tmo++;
            req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        end
    endtask

    task automatic issue(input bit k, input logic [2:0] op, input logic [DW-1:0] a, b, c);
        if (k) run_cmds(1'b0, 3'd0, '0, '0, '0, 1'b1, op, a, b, c, 1'b0);
        else   run_cmds(1'b1, op, a, b, c, 1'b0, 3'd0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_idle();
        int g;
        bit ok;
        rsp_ready_i = 1'b1;
        g = 0; ok = 1'b0;
        while (!ok && g < 200) begin
            @(negedge clk_i);
            ok = (exp_q.size() == 0) && !busy_o;
            g++;
        end
        if (!ok) tmo++;
        @(posedge clk_i); #1;
    endtask

    initial begin
        logic [DW-1:0] all01, all02, all10, ident, seq, ra, rb, rc;
        int n, g;
        bit v0, v1;
        all01 = {9{8'h01}}; all02 = {9{8'h02}}; all10 = {9{8'h10}};
        ident = {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01};
        seq   = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};

        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        issue(1'b0, 3'b000, all01, all02, rnd_mat());
        wait_idle();
        issue(1'b1, 3'b010, ident, seq, rnd_mat());
        wait_idle();
        issue(1'b1, 3'b101, all02, rnd_mat(), rnd_mat());
        wait_idle();
        issue(1'b0, 3'b011, all10, all10, all01);
        wait_idle();
        issue(1'b0, 3'b100, all10, all10, all01);
        wait_idle();

        // both requesters hammer ADD: alternating grants, 3-cycle spacing
        phase = 1;
        req0_valid_i = 1'b1; req0_op_i = 3'b000; req0_a_i = rnd_mat(); req0_b_i = rnd_mat();
        req1_valid_i = 1'b1; req1_op_i = 3'b000; req1_a_i = rnd_mat(); req1_b_i = rnd_mat();
        n = 0; g = 0;
        while (n < 8 && g < 60) begin
            @(negedge clk_i);
            if ((req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o)) n++;
            @(posedge clk_i); #1;
            g++;
        end
        if (n < 8) tmo++;
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; phase = 0;
        wait_idle();

        // backpressure: hold the response 5 cycles with req1 waiting
        rsp_ready_i = 1'b0;
        issue(1'b0, 3'b001, rnd_mat(), rnd_mat(), rnd_mat());
        g = 0;
        while (!rsp_valid_o && g < 20) begin @(posedge clk_i); #1; g++; end
        if (!rsp_valid_o) tmo++;
        phase = 2;
        req1_valid_i = 1'b1; req1_op_i = 3'b000; req1_a_i = rnd_mat(); req1_b_i = rnd_mat();
        repeat (5) @(posedge clk_i);
        #1 rsp_ready_i = 1'b1;
        run_cmds(1'b0, 3'd0, '0, '0, '0, 1'b1, req1_op_i, req1_a_i, req1_b_i, req1_c_i, 1'b0);
        phase = 0;
        wait_idle();

        issue(1'b1, 3'b111, rnd_mat(), rnd_mat(), rnd_mat());
        wait_idle();
        issue(1'b0, 3'b110, rnd_mat(), rnd_mat(), rnd_mat());
        wait_idle();

        // reset during PASS2 of a MULADD: dropped, then requester 0 wins
        issue(1'b0, 3'b011, rnd_mat(), rnd_mat(), rnd_mat());
        @(posedge clk_i); #1 rst_ni = 1'b0;
        phase = 3;
        @(posedge clk_i); #1 rst_ni = 1'b1;
        run_cmds(1'b1, 3'b000, rnd_mat(), rnd_mat(), rnd_mat(),
                 1'b1, 3'b000, rnd_mat(), rnd_mat(), rnd_mat(), 1'b0);
        phase = 0;
        wait_idle();

        for (int it = 0; it < 40; it++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1)) | !v0;
            ra = rnd_mat(); rb = rnd_mat(); rc = rnd_mat();
            run_cmds(v0, 3'($urandom_range(0, 7)), ra, rb, rc,
                     v1, 3'($urandom_range(0, 7)), rnd_mat(), rnd_mat(), rnd_mat(), 1'b1);
        end
        wait_idle();

        final_req = 1'b1;
        g = 0;
        while (!mon_done && g < 10) begin @(posedge clk_i); g++; end
        if (!mon_done) begin
            $display("FAIL monitor_final did not complete");
            $fatal(1, "monitor stalled");
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
